// File: rtl/s_z_ctrl.sv
// s_z_ctrl: clears, accumulates into and arbitrates the s_z_mem result memory. Latency: beat written one cycle after accept.
// Backpressure: prod_ready_o high only in ACCUM; host reads served only in IDLE. Define S_Z_SAT_EN for saturating accumulate.
module s_z_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] len_i,
    input  logic                  prod_valid_i,
    output logic                  prod_ready_o,
    input  logic [ADDR_WIDTH-1:0] prod_addr_i,
    input  logic [DATA_WIDTH-1:0] prod_data_i,
    input  logic                  prod_last_i,
    input  logic                  host_rd_req_i,
    input  logic [ADDR_WIDTH-1:0] host_rd_addr_i,
    output logic                  host_rd_valid_o,
    output logic [DATA_WIDTH-1:0] host_rd_data_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_waddr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic [ADDR_WIDTH-1:0] mem_raddr_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  ovf_o,
    output logic                  addr_err_o
);

    typedef enum logic [2:0] {IDLE, CLEAR, ACCUM, DRAIN, DONE} state_t;

    localparam logic [ADDR_WIDTH-1:0] ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                state;
    logic [ADDR_WIDTH-1:0] len_q;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  ready_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  err_q;
    logic                  host_pend;
    logic [ADDR_WIDTH-1:0] raddr_q;

    logic                  s2_vld;
    logic [ADDR_WIDTH-1:0] s2_addr;
    logic [DATA_WIDTH-1:0] s2_data;

    logic                  fwd_vld;
    logic [ADDR_WIDTH-1:0] fwd_addr;
    logic [DATA_WIDTH-1:0] fwd_data;

    logic                  accept;
    logic                  in_range;
    logic                  host_take;
    logic [ADDR_WIDTH-1:0] raddr;
    logic [DATA_WIDTH-1:0] base;
    logic [DATA_WIDTH-1:0] acc;
    logic                  clamp;
    logic                  we;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;

    assign accept    = prod_valid_i & ready_q;
    assign in_range  = prod_addr_i < len_q;
    assign host_take = (state == IDLE) & host_rd_req_i;

    // Read port keeps its last address when nobody needs it.
    always_comb begin
        raddr = raddr_q;
        if (accept && in_range)
            raddr = prod_addr_i;
        else if (host_take)
            raddr = host_rd_addr_i;
    end

    // The RAM misses the write issued one cycle earlier, so take it from the forwarding register.
    assign base = (fwd_vld && (fwd_addr == s2_addr)) ? fwd_data : mem_rdata_i;

`ifdef S_Z_SAT_EN
    logic [DATA_WIDTH:0] sum_ext;
    logic                ovf_q;

    localparam logic [DATA_WIDTH-1:0] MAX_V = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] MIN_V = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    always_comb begin
        sum_ext = {base[DATA_WIDTH-1], base} + {s2_data[DATA_WIDTH-1], s2_data};
        clamp   = sum_ext[DATA_WIDTH] != sum_ext[DATA_WIDTH-1];
        acc     = sum_ext[DATA_WIDTH-1:0];
        if (clamp)
            acc = sum_ext[DATA_WIDTH] ? MIN_V : MAX_V;
    end

    always_ff @(posedge clk) begin
        if (!rstn)
            ovf_q <= 1'b0;
        else if (state == IDLE && start_i)
            ovf_q <= 1'b0;
        else if (s2_vld && clamp)
            ovf_q <= 1'b1;
    end

    assign ovf_o = ovf_q;
`else
    assign acc   = base + s2_data;
    assign clamp = 1'b0;
    assign ovf_o = 1'b0;
`endif

    always_comb begin
        we    = (state == CLEAR) | s2_vld;
        waddr = (state == CLEAR) ? clr_addr : s2_addr;
        wdata = '0;
        if (state != CLEAR && s2_vld)
            wdata = acc;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= IDLE;
            len_q     <= '0;
            clr_addr  <= '0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            host_pend <= 1'b0;
            raddr_q   <= '0;
            s2_vld    <= 1'b0;
            s2_addr   <= '0;
            s2_data   <= '0;
            fwd_vld   <= 1'b0;
            fwd_addr  <= '0;
            fwd_data  <= '0;
        end else begin
            raddr_q   <= raddr;
            host_pend <= host_take;
            s2_vld    <= accept & in_range;
            s2_addr   <= prod_addr_i;
            s2_data   <= prod_data_i;
            fwd_vld   <= we;
            fwd_addr  <= waddr;
            fwd_data  <= wdata;
            done_q    <= 1'b0;
            if (accept && !in_range)
                err_q <= 1'b1;

            case (state)
                IDLE: begin
                    if (start_i) begin
                        len_q    <= len_i;
                        err_q    <= 1'b0;
                        clr_addr <= '0;
                        busy_q   <= 1'b1;
                        if (len_i != '0) begin
                            state <= CLEAR;
                        end else begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end
                    end
                end
                CLEAR: begin
                    clr_addr <= clr_addr + ONE;
                    if (clr_addr == len_q - ONE) begin
                        state   <= ACCUM;
                        ready_q <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (accept && prod_last_i) begin
                        state   <= DRAIN;
                        ready_q <= 1'b0;
                    end
                end
                DRAIN: begin
                    state  <= DONE;
                    done_q <= 1'b1;
                end
                DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign prod_ready_o    = ready_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign addr_err_o      = err_q;
    assign host_rd_valid_o = host_pend;
    assign host_rd_data_o  = host_pend ? mem_rdata_i : '0;
    assign mem_we_o        = we;
    assign mem_waddr_o     = waddr;
    assign mem_wdata_o     = wdata;
    assign mem_raddr_o     = raddr;

endmodule

// File: doc/s_z_ctrl.md
# s_z_ctrl

Sequencer and port arbiter for the full-convolution result memory (`s_z_mem`, 1-cycle registered read, read-before-write). It clears the active result window, accumulates a stream of partial products into it by read-modify-write at full throughput with hazard forwarding, and then hands the memory's read port to the host. It sits between the convolution MAC datapath and `s_z_mem`, and drives all of that memory's ports.

## Interface
- DATA_WIDTH, 16, sample / accumulator width (two's complement)
- ADDR_WIDTH, 6, result memory address width
- clk  in  1  system clock, all logic on rising edge
- rstn  in  1  reset, synchronous, active-low
- start_i  in  1  start one convolution; sampled only in IDLE
- len_i  in  ADDR_WIDTH  result length (sizeX+sizeY-1), captured on start
- prod_valid_i / prod_ready_o  in/out  1  product stream handshake; a beat transfers when both are high
- prod_addr_i  in  ADDR_WIDTH  target index i+j
- prod_data_i  in  DATA_WIDTH  signed partial product
- prod_last_i  in  1  final product of the run
- host_rd_req_i  in  1  host read request
- host_rd_addr_i  in  ADDR_WIDTH  host read address
- host_rd_valid_o  out  1  host read data valid
- host_rd_data_o  out  DATA_WIDTH  host read data
- mem_we_o, mem_waddr_o, mem_wdata_o  out  1/ADDR_WIDTH/DATA_WIDTH  to `s_z_mem` write port
- mem_raddr_o  out  ADDR_WIDTH  to `s_z_mem` read address
- mem_rdata_i  in  DATA_WIDTH  from `s_z_mem` read data
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle completion pulse
- ovf_o  out  1  sticky saturation flag
- addr_err_o  out  1  sticky flag: a product had addr >= len

## Operation
- FSM states: IDLE, CLEAR, ACCUM, DRAIN, DONE. Reset forces IDLE.
- IDLE + start_i:
  - Capture len. ovf_o and addr_err_o clear.
  - Next state is CLEAR if len != 0; otherwise DONE.
- CLEAR:
  - Write 0 to addresses 0..len-1, one per cycle, ascending (mem_we_o=1).
  - After writing len-1, go to ACCUM. The state lasts exactly len cycles.
- ACCUM:
  - prod_ready_o=1.
  - Accepted beat at cycle t: mem_raddr_o=prod_addr_i in cycle t, and the beat is registered into stage S2.
  - Cycle t+1 (S2):
    - base = mem_rdata_i. If the previous cycle issued a write to the same address, base = that write's data instead (forwarding register).
    - Issue mem_we_o=1, mem_waddr_o=addr, mem_wdata_o=base+data.
  - A beat with prod_addr_i >= len is accepted, but no read or write is issued and addr_err_o is set.
  - An accepted beat with prod_last_i high moves the FSM to DRAIN.
- DRAIN: prod_ready_o=0. After one cycle (the last S2 write issues), go to DONE.
- DONE: done_o=1 for one cycle, then IDLE.
- Host read:
  - Served only in IDLE. host_rd_req_i drives mem_raddr_o=host_rd_addr_i.
  - Next cycle: host_rd_valid_o=1 and host_rd_data_o=mem_rdata_i.
  - Requests outside IDLE are ignored (no valid). A start_i in the same cycle as a host request still captures the request; its valid appears in the first CLEAR cycle.
- Arithmetic: signed DATA_WIDTH add; overflow handling per Configuration.
- start_i outside IDLE is ignored.

## Timing
- Reset values: state IDLE, all outputs 0, S2 and forwarding register invalid.
- rstn low mid-run: the pending S2 write is dropped (mem_we_o=0 in the following cycle), and the partial memory contents are undefined for the next run.
- Product-to-memory latency:
  - A beat accepted in cycle t is written at the edge ending cycle t+1.
  - A read in cycle t+1 or later sees the updated value, via forwarding or RAM.
- Throughput: one product per cycle in ACCUM, with back-to-back same-address beats allowed.
- start to first ACCUM cycle: 1+len cycles. Final beat to done_o: 2 cycles.
- mem_raddr_o holds its last value when unused; mem_waddr_o/mem_wdata_o are don't-care when mem_we_o=0.

## Configuration
- S_Z_SAT_EN defined: the accumulate saturates to +2^(DATA_WIDTH-1)-1 or -2^(DATA_WIDTH-1), and ovf_o sets on any clamp.
- S_Z_SAT_EN undefined: the accumulate wraps modulo 2^DATA_WIDTH, and ovf_o is tied 0.

## Test plan
- Clear check: preload the memory with 0xFFFF, start with len=5, no products except a single last beat (addr 0, data 0) -> CLEAR lasts 5 cycles; host reads 0..4 return 0 and address 5 keeps 0xFFFF; done_o pulses once.
- Full convolution: x={1,2,3}, y={1,1}, len=4, all products streamed back-to-back -> host reads {1,3,5,3}.
- Hazard: 4 consecutive beats to addr 2 with data 7 -> mem[2]=28. Also beats alternating addr 1/2 with data 1 over 6 beats -> mem[1]=3, mem[2]=3.
- Saturation (S_Z_SAT_EN): two beats to addr 0 with data 0x7000 -> mem[0]=0x7FFF, ovf_o=1. Without the macro -> mem[0]=0xE000, ovf_o=0.
- Errors and arbitration:
  - A beat with addr=len -> no write, addr_err_o=1.
  - host_rd_req_i during ACCUM -> no host_rd_valid_o.
  - start_i during ACCUM -> ignored.
  - len=0 -> done_o 1 cycle after start.
- Reset: deassert rstn during ACCUM -> busy_o=0 and mem_we_o=0 the next cycle; a fresh run afterwards gives correct results.
